// File: rtl/seg_bus_pkg.sv
// -----------------------------------------------------------------------------
// seg_bus_pkg
// Shared types and helpers for the segmented data-memory bus.
//   state_e    : bus FSM states
//   SLV_*      : slave index map (iram, dram, vga)
//   sa_width   : width of the per-beat slave address carried on mosi
//   idx_width  : width of an index into n items (at least 1 bit)
// -----------------------------------------------------------------------------
package seg_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int SLV_IRAM = 0;
  localparam int SLV_DRAM = 1;
  localparam int SLV_VGA  = 2;

  // Word address bits below the decode field, plus the beat number appended
  // as the least significant part of the slave address.
  function automatic int sa_width(input int addr_w, input int dec_w,
                                  input int data_w, input int lane_w);
    return addr_w - dec_w - $clog2(data_w / 8) + $clog2(data_w / lane_w);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_bus_if.sv
// -----------------------------------------------------------------------------
// seg_bus_if
// Bundles the CPU-side request port and the slave-side segmented bus.
//   req/rw/addr/wdata : CPU request          rdata/ack/err : CPU response
//   cs_n/mosi         : slave select + beat  miso/s_rdy    : slave response
// Modports:
//   master : view of the seg_bus block itself (drives responses and slaves)
//   slave  : view of the surroundings (CPU and slaves)
// -----------------------------------------------------------------------------
interface seg_bus_if
  import seg_bus_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 32,
  parameter int DEC_W  = 12,
  parameter int NSLV   = 3
) ();

  localparam int SA_W   = sa_width(ADDR_W, DEC_W, DATA_W, LANE_W);
  localparam int MOSI_W = 1 + LANE_W + SA_W;

  logic                   req;
  logic                   rw;
  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_W-1:0]      rdata;
  logic                   ack;
  logic                   err;
  logic [NSLV-1:0]        cs_n;
  logic [MOSI_W-1:0]      mosi;
  logic [NSLV*LANE_W-1:0] miso;
  logic [NSLV-1:0]        s_rdy;

  modport master (
    input  req, rw, addr, wdata, miso, s_rdy,
    output rdata, ack, err, cs_n, mosi
  );

  modport slave (
    output req, rw, addr, wdata, miso, s_rdy,
    input  rdata, ack, err, cs_n, mosi
  );

endinterface

// File: rtl/seg_bus_dec.sv
// -----------------------------------------------------------------------------
// seg_bus_dec
// Combinational address decoder: the top DEC_W address bits form the slave
// index; the access is mapped when that index is below NSLV.
//   addr   in  : CPU byte address
//   sel    out : slave index (truncated, meaningful only when mapped)
//   mapped out : index selects an existing slave
// -----------------------------------------------------------------------------
module seg_bus_dec
  import seg_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEC_W  = 12,
  parameter int NSLV   = 3,
  parameter int SEL_W  = idx_width(NSLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  sel,
  output logic              mapped
);

  logic [DEC_W-1:0] idx;

  assign idx    = addr[ADDR_W-1 -: DEC_W];
  // Compare the full decode field so aliases of small indices stay unmapped.
  assign mapped = idx < DEC_W'(NSLV);
  assign sel    = idx[SEL_W-1:0];

  // Low address bits carry the word offset, not the slave index.
  logic unused_low;
  assign unused_low = ^addr[ADDR_W-DEC_W-1:0];

endmodule

// File: rtl/seg_bus.sv
// -----------------------------------------------------------------------------
// seg_bus
// Splits one DATA_W CPU access into DATA_W/LANE_W slave beats (low lane
// first), selects one of NSLV slaves from the top address bits, and
// reassembles read data. Unmapped accesses complete with ack+err.
//   sck   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg_bus_if.master (CPU request/response + slave bus)
// Optional: define SEG_BUS_TIMEOUT_EN to end a beat with ack+err after
// TIMEOUT consecutive cycles without the selected slave's s_rdy.
// -----------------------------------------------------------------------------
module seg_bus
  import seg_bus_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LANE_W  = 16,
  parameter int ADDR_W  = 32,
  parameter int DEC_W   = 12,
  parameter int NSLV    = 3,
  parameter int TIMEOUT = 15
) (
  input logic      sck,
  input logic      rst_n,
  seg_bus_if.master bus
);

  localparam int BEATS    = DATA_W / LANE_W;
  localparam int BEAT_W   = idx_width(BEATS);
  localparam int BEAT_LOG = $clog2(BEATS);
  localparam int OFF_W    = $clog2(DATA_W / 8);
  localparam int WORD_W   = ADDR_W - DEC_W - OFF_W;
  localparam int SA_W     = sa_width(ADDR_W, DEC_W, DATA_W, LANE_W);
  localparam int MOSI_W   = 1 + LANE_W + SA_W;
  localparam int SEL_W    = idx_width(NSLV);

  state_e              state_q, state_nx;
  logic [BEAT_W-1:0]   beat_q, beat_nx;
  logic [SEL_W-1:0]    sel_q, sel_nx;
  logic                rw_q, rw_nx;
  logic [WORD_W-1:0]   word_q, word_nx;
  logic [DATA_W-1:0]   wdata_q, wdata_nx;
  logic [DATA_W-1:0]   rdata_q;
  logic                ack_q, err_q;
  logic [NSLV-1:0]     cs_n_q, cs_n_d;
  logic [MOSI_W-1:0]   mosi_q, mosi_d;

  logic [SEL_W-1:0]    dec_sel;
  logic                dec_mapped;
  logic                rdy_sel;

`ifdef SEG_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_nx;
`endif

  seg_bus_dec #(
    .ADDR_W (ADDR_W),
    .DEC_W  (DEC_W),
    .NSLV   (NSLV),
    .SEL_W  (SEL_W)
  ) u_dec (
    .addr   (bus.addr),
    .sel    (dec_sel),
    .mapped (dec_mapped)
  );

  // Only the latched slave's strobe can complete a beat.
  assign rdy_sel = |(bus.s_rdy & (NSLV'(1) << sel_q));

  function automatic logic [SA_W-1:0] slave_addr(input logic [WORD_W-1:0] word,
                                                 input logic [BEAT_W-1:0] beat);
    return (SA_W'(word) << BEAT_LOG) | SA_W'(beat);
  endfunction

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state_q;
    beat_nx  = beat_q;
    sel_nx   = sel_q;
    rw_nx    = rw_q;
    word_nx  = word_q;
    wdata_nx = wdata_q;
`ifdef SEG_BUS_TIMEOUT_EN
    cnt_nx   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          rw_nx    = bus.rw;
          word_nx  = bus.addr[ADDR_W-DEC_W-1 -: WORD_W];
          wdata_nx = bus.wdata;
          sel_nx   = dec_sel;
          beat_nx  = '0;
          state_nx = dec_mapped ? ST_XFER : ST_ERR;
`ifdef SEG_BUS_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      ST_XFER: begin
        if (rdy_sel) begin
`ifdef SEG_BUS_TIMEOUT_EN
          cnt_nx = '0;
`endif
          if (beat_q == BEAT_W'(BEATS - 1)) state_nx = ST_DONE;
          else                              beat_nx  = beat_q + 1'b1;
        end
`ifdef SEG_BUS_TIMEOUT_EN
        // cnt_q counts completed wait cycles; this is the TIMEOUT-th one.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) state_nx = ST_ERR;
        else                                    cnt_nx   = cnt_q + 1'b1;
`endif
      end
      ST_DONE, ST_ERR: state_nx = ST_IDLE;
      default:         state_nx = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they are valid for the
    // whole cycle that state is held.
    cs_n_d = '1;
    mosi_d = '0;
    if (state_nx == ST_XFER) begin
      cs_n_d = ~(NSLV'(1) << sel_nx);
      mosi_d = {rw_nx, wdata_nx[beat_nx*LANE_W +: LANE_W], slave_addr(word_nx, beat_nx)};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      sel_q   <= '0;
      rw_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cs_n_q  <= '1;
      mosi_q  <= '0;
`ifdef SEG_BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_nx;
      beat_q  <= beat_nx;
      sel_q   <= sel_nx;
      rw_q    <= rw_nx;
      word_q  <= word_nx;
      wdata_q <= wdata_nx;
      ack_q   <= (state_nx == ST_DONE) || (state_nx == ST_ERR);
      err_q   <= (state_nx == ST_ERR);
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
`ifdef SEG_BUS_TIMEOUT_EN
      cnt_q   <= cnt_nx;
`endif
      if (state_nx == ST_ERR)
        rdata_q <= '0;
      else if (state_q == ST_XFER && rdy_sel && !rw_q)
        rdata_q[beat_q*LANE_W +: LANE_W] <= bus.miso[sel_q*LANE_W +: LANE_W];
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.cs_n  = cs_n_q;
  assign bus.mosi  = mosi_q;

endmodule

// File: tb/tb_seg_bus.sv
// -----------------------------------------------------------------------------
// tb_seg_bus
// Directed bench for seg_bus with default parameters. Expected beats and
// completions are queued by the stimulus; a negedge monitor pops and compares
// whenever a beat completes or ack is presented.
// -----------------------------------------------------------------------------
module tb_seg_bus;

  logic sck = 1'b0;
  logic rst_n = 1'b1;
  always #5 sck = ~sck;

  seg_bus_if #(.DATA_W(32), .LANE_W(16), .ADDR_W(32), .DEC_W(12), .NSLV(3)) bus ();

  seg_bus #(.DATA_W(32), .LANE_W(16), .ADDR_W(32), .DEC_W(12), .NSLV(3), .TIMEOUT(15)) dut (
    .sck   (sck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Slave model: every slave returns the half of rd_word named by the beat
  // bit of the slave address on mosi.
  logic [31:0] rd_word;
  logic [15:0] rd_lane;
  assign rd_lane  = bus.mosi[0] ? rd_word[31:16] : rd_word[15:0];
  assign bus.miso = {rd_lane, rd_lane, rd_lane};

  typedef struct {
    logic [35:0] mosi;
    logic [2:0]  cs_n;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } done_t;

  beat_t exp_beats[$];
  done_t exp_done[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] mk_mosi(input logic rw, input logic [15:0] lane,
                                          input logic [18:0] sa);
    return {rw, lane, sa};
  endfunction

  task automatic push_beat(input logic rw, input logic [15:0] lane,
                           input logic [18:0] sa, input logic [2:0] cs_n);
    exp_beats.push_back('{mosi: mk_mosi(rw, lane, sa), cs_n: cs_n});
  endtask

  task automatic push_done(input logic [31:0] rdata, input logic err);
    exp_done.push_back('{rdata: rdata, err: err});
  endtask

  // Monitor: a beat completes when a selected slave has s_rdy high.
  always @(negedge sck) begin
    if (rst_n) begin
      if ((~bus.cs_n & bus.s_rdy) != 3'b000) begin
        if (exp_beats.size() == 0) check("beat_expected", 0, 1);
        else begin
          beat_t b;
          b = exp_beats.pop_front();
          check("beat_cs_n", bus.cs_n, b.cs_n);
          check("beat_mosi", bus.mosi, b.mosi);
        end
      end
      if (bus.ack) begin
        if (exp_done.size() == 0) check("ack_expected", 0, 1);
        else begin
          done_t d;
          d = exp_done.pop_front();
          check("done_rdata", bus.rdata, d.rdata);
          check("done_err", bus.err, d.err);
        end
      end else if (bus.err) begin
        check("err_without_ack", bus.err, 1'b0);
      end
    end
  end

  // Issue one request at #1 after an edge in IDLE; measure cycles from the
  // sampling edge to ack. Request inputs are scrambled once accepted.
  task automatic run(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input string name);
    int n;
    bus.req   = 1'b1;
    bus.rw    = rw;
    bus.addr  = addr;
    bus.wdata = wdata;
    @(posedge sck);
    #1;
    bus.req   = 1'b0;
    bus.rw    = ~rw;
    bus.addr  = ~addr;
    bus.wdata = ~wdata;
    n = 0;
    do begin
      @(negedge sck);
      n++;
    end while (!bus.ack && n < 40);
    check(name, n, exp_lat);
    @(posedge sck);
    #1;
  endtask

  initial begin
    bus.req   = 1'b0;
    bus.rw    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.s_rdy = 3'b111;
    rd_word   = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ack",   bus.ack,   1'b0);
    check("rst_err",   bus.err,   1'b0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_cs_n",  bus.cs_n,  3'b111);
    check("rst_mosi",  bus.mosi,  36'h0);
    @(posedge sck);
    @(posedge sck);
    #1 rst_n = 1'b1;

    // Dram read: word 2, slave addresses 4 then 5.
    rd_word = 32'h1234_5678;
    push_beat(1'b0, 16'h0000, 19'd4, 3'b101);
    push_beat(1'b0, 16'h0000, 19'd5, 3'b101);
    push_done(32'h1234_5678, 1'b0);
    run(1'b0, 32'h0010_0008, 32'h0, 3, "dram_rd_latency");

    // Dram write: rdata keeps the previous read.
    push_beat(1'b1, 16'hBEEF, 19'd4, 3'b101);
    push_beat(1'b1, 16'hDEAD, 19'd5, 3'b101);
    push_done(32'h1234_5678, 1'b0);
    run(1'b1, 32'h0010_0008, 32'hDEAD_BEEF, 3, "dram_wr_latency");

    // Iram read with four wait cycles on beat 1.
    rd_word = 32'hCAFE_F00D;
    push_beat(1'b0, 16'h0000, 19'd8, 3'b110);
    push_beat(1'b0, 16'h0000, 19'd9, 3'b110);
    push_done(32'hCAFE_F00D, 1'b0);
    fork
      run(1'b0, 32'h0000_0010, 32'h0, 7, "wait_latency");
      begin
        @(posedge sck);
        @(posedge sck);
        #1 bus.s_rdy = 3'b000;
        repeat (4) begin
          @(negedge sck);
          check("wait_mosi", bus.mosi, mk_mosi(1'b0, 16'h0000, 19'd9));
          check("wait_cs_n", bus.cs_n, 3'b110);
        end
        @(posedge sck);
        #1 bus.s_rdy = 3'b111;
      end
    join

    // Vga write: word 1, slave addresses 2 then 3.
    push_beat(1'b1, 16'h0304, 19'd2, 3'b011);
    push_beat(1'b1, 16'h0102, 19'd3, 3'b011);
    push_done(32'hCAFE_F00D, 1'b0);
    run(1'b1, 32'h0020_0004, 32'h0102_0304, 3, "vga_wr_latency");

    // Unmapped: first index past the last slave, and the top index.
    push_done(32'h0, 1'b1);
    run(1'b0, 32'h0030_0000, 32'h0, 1, "unmapped_latency");
    push_done(32'h0, 1'b1);
    run(1'b1, 32'hFFF0_0004, 32'h5555_AAAA, 1, "unmapped_top_latency");

`ifdef SEG_BUS_TIMEOUT_EN
    // Slave never ready: err after exactly 15 wait cycles.
    bus.s_rdy = 3'b000;
    push_done(32'h0, 1'b1);
    run(1'b0, 32'h0010_0008, 32'h0, 16, "timeout_latency");
    bus.s_rdy = 3'b111;
`endif

    // Abort mid-transfer, then a normal read.
    rd_word   = 32'h0BAD_F00D;
    bus.s_rdy = 3'b000;
    bus.req   = 1'b1;
    bus.rw    = 1'b0;
    bus.addr  = 32'h0010_0008;
    @(posedge sck);
    #1 bus.req = 1'b0;
    @(negedge sck);
    check("abort_cs_busy", bus.cs_n, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs_n",  bus.cs_n,  3'b111);
    check("abort_ack",   bus.ack,   1'b0);
    check("abort_rdata", bus.rdata, 32'h0);
    @(posedge sck);
    #1;
    rst_n     = 1'b1;
    bus.s_rdy = 3'b111;
    push_beat(1'b0, 16'h0000, 19'd4, 3'b101);
    push_beat(1'b0, 16'h0000, 19'd5, 3'b101);
    push_done(32'h0BAD_F00D, 1'b0);
    run(1'b0, 32'h0010_0008, 32'h0, 3, "post_abort_latency");

    repeat (3) @(posedge sck);
    check("beats_drained", exp_beats.size(), 0);
    check("dones_drained", exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_bus.md
# seg_bus

Parametrised successor to the two-beat data-memory bus. Splits one wide CPU access into `DATA_W/LANE_W` narrow beats and decodes the address into one of `NSLV` chip selects. Drives the selected slave beat by beat with a ready handshake and reassembles read data. Sits between the core's load/store port and the instruction RAM, data RAM and VGA slaves. Reports unmapped accesses as errors, and optionally reports slave timeouts.

## Interface
- `DATA_W`, 32, CPU data width; integer multiple of `LANE_W`.
- `LANE_W`, 16, slave data width per beat.
- `ADDR_W`, 32, CPU address width.
- `DEC_W`, 12, number of top address bits used as the slave index.
- `NSLV`, 3, number of slaves: 0 = iram, 1 = dram, 2 = vga.
- `TIMEOUT`, 15, maximum wait cycles per beat; used only with `SEG_BUS_TIMEOUT_EN`.
- `sck` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: access request; sampled only in IDLE.
- `rw` in 1: 1 = write, 0 = read.
- `addr` in `ADDR_W`: byte address; low `log2(DATA_W/8)` bits are ignored.
- `wdata` in `DATA_W`: write data.
- `rdata` out `DATA_W`: assembled read data; valid while `ack` is high.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle error pulse; always coincides with `ack`.
- `cs_n` out `NSLV`: one-hot-low slave selects.
- `mosi` out `1+LANE_W+SA_W`: `{rw, lane data, slave address}`.
  - `SA_W = ADDR_W-DEC_W-log2(DATA_W/8)+log2(BEATS)`.
  - `BEATS = DATA_W/LANE_W`.
- `miso` in `NSLV*LANE_W`: per-slave read lanes; slave i occupies bits `[i*LANE_W +: LANE_W]`.
- `s_rdy` in `NSLV`: per-slave beat-complete strobe.

## Operation
- **Slave index:** `sel = addr[ADDR_W-1 -: DEC_W]`. The access is mapped when `sel < NSLV`.
- **Latching:** `rw`, `addr`, `wdata` and `sel` are latched on acceptance. Input changes while busy have no effect.
- **State IDLE:**
  - `req` high and mapped → XFER, with beat = 0.
  - `req` high and unmapped → ERR.
- **State XFER:**
  - `cs_n[sel]` is low; every other select is high.
  - `mosi = {rw, wdata lane[beat], {word_addr, beat}}`.
  - Lane 0 is `wdata[LANE_W-1:0]`; beats run low lane first.
  - On a rising edge with `s_rdy[sel]` high:
    - a read captures `miso` lane `sel` into `rdata` lane `beat`;
    - the block then advances beat, or goes to DONE after beat `BEATS-1`.
  - `s_rdy` from unselected slaves is ignored.
- **State DONE:** `ack` = 1, `cs_n` all high → IDLE. `rdata` holds until the next acceptance.
- **State ERR:** `ack` = 1, `err` = 1, `rdata` = 0 → IDLE. No slave is selected.
- **Write `rdata`:** `rdata` is not updated on writes.
- **`req` during DONE/ERR:** ignored. The requester must hold `req` until `ack`. A new request is accepted in the following IDLE cycle.
- **Reset:** asserting `rst_n` low at any time aborts immediately and `cs_n` goes all high asynchronously. There is no partial `ack`.

## Timing
- **Reset values:**
  - state IDLE, beat 0;
  - `ack` 0, `err` 0;
  - `rdata` 0;
  - `cs_n` all 1;
  - `mosi` 0.
- **Read/write latency:** with `s_rdy` held high, `ack` is high in cycle `BEATS+1` after the `req` sampling edge. For the defaults that is cycle 3.
- **Throughput:** minimum spacing between accepted requests is `BEATS+2` cycles.
- **Unmapped access:** `ack` and `err` are high in the cycle right after the sampling edge.
- **Wait states:** each cycle with `s_rdy[sel]` low extends the current beat by one cycle. `mosi` and `cs_n` are stable throughout.
- All outputs are registered.

## Configuration
- **`SEG_BUS_TIMEOUT_EN` defined:**
  - a per-beat counter resets on every beat advance;
  - if `s_rdy[sel]` stays low for `TIMEOUT` consecutive XFER cycles, the block goes to ERR;
  - ERR pulses `ack` and `err`, and `rdata` = 0;
  - the counter width is `$clog2(TIMEOUT+1)`.
- **Not defined:** XFER waits indefinitely and `err` asserts only for unmapped addresses.

## Structure
- **`seg_bus_pkg`:**
  - state enum (IDLE, XFER, DONE, ERR);
  - slave index constants `SLV_IRAM`=0, `SLV_DRAM`=1, `SLV_VGA`=2;
  - a function computing `SA_W`.
- **Sub-module `seg_bus_dec`:** combinational `addr` → `sel` plus mapped flag; parametrised by `ADDR_W`, `DEC_W` and `NSLV`.

## Test plan
- **Reset:** `rst_n` = 0 → `ack` = 0, `err` = 0, `rdata` = 0, `cs_n` = 3'b111.
- **Dram read:** `addr` = 32'h0010_0008, `s_rdy` high; slave returns 16'h5678 on beat 0 and 16'h1234 on beat 1.
  - `mosi` slave addresses are `{2, 0}` then `{2, 1}`.
  - `ack` in cycle 3 with `rdata` = 32'h1234_5678.
- **Dram write:** `wdata` = 32'hDEAD_BEEF → beat 0 `mosi` lane = 16'hBEEF with `rw` = 1, beat 1 lane = 16'hDEAD; `cs_n` = 3'b101.
- **Wait states:** `s_rdy` low for 4 cycles on beat 1 → `ack` in cycle 7; `mosi` is unchanged during the wait.
- **Unmapped access:** `addr` = 32'h0030_0000 → `ack` = `err` = 1 next cycle, `cs_n` never low.
- **Timeout (with `SEG_BUS_TIMEOUT_EN`):** `s_rdy` never high → `err` after exactly 15 wait cycles.
- **Abort:** assert `rst_n` mid-XFER → `cs_n` goes all high asynchronously; the next request completes normally.
